uvmt_axis_st_echo_dut: RTL and testbench

Loopback responder DUT for the AXI-Stream agent self-test bench. Sits at the far end of the master agent's stream: it accepts beats as an AXI-Stream slave, buffers them in a beat FIFO, and returns them to the slave agent as an AXI-Stream master with `tid`/`tdest` swapped. This turns the bench's straight-wire connection into a real responder with backpressure, buffering and latency.

---
 rtl/uvmt_axis_st_echo_dut.sv | 170 +++++++++++++++++
 tb/tb_uvmt_axis_st_echo_dut.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_axis_st_echo_dut.sv
// uvmt_axis_st_echo_dut
//   AXI-Stream loopback responder. Inbound beats are buffered in a beat FIFO
//   and returned on the outbound stream with tid/tdest swapped. Every other
//   field passes through bit-exact. The head of the FIFO is held in a
//   registered output stage, so there is one cycle of latency.
//
// Ports
//   clk, reset            : single clock, asynchronous active-high reset
//   s_t*                  : AXI-Stream slave (inbound)
//   m_t*                  : AXI-Stream master (outbound, tid/tdest swapped)
//   pkt_cnt               : m_tlast beats accepted, wraps mod 2^16
//   beat_cnt              : outbound beats accepted, wraps mod 2^16
//
// Configuration
//   UVMT_AXIS_ST_ECHO_STORE_FWD_EN : when defined, the output is held until a
//   complete packet is buffered. A full FIFO with no complete packet releases
//   the oversize packet through its tlast so the stream cannot deadlock.
//   When undefined, beats cut through as soon as they are stored.
module uvmt_axis_st_echo_dut #(
    parameter int DATA_WIDTH  = 32,
    parameter int ROUTE_WIDTH = 8,
    parameter int USER_WIDTH  = 8,
    parameter int DEPTH       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tstrb,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic [ROUTE_WIDTH-1:0]  s_tid,
    input  logic [ROUTE_WIDTH-1:0]  s_tdest,
    input  logic [USER_WIDTH-1:0]   s_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,
    output logic [ROUTE_WIDTH-1:0]  m_tid,
    output logic [ROUTE_WIDTH-1:0]  m_tdest,
    output logic [USER_WIDTH-1:0]   m_tuser,
    output logic [15:0]             pkt_cnt,
    output logic [15:0]             beat_cnt
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // id/dest hold the outbound values, so the swap happens once at the write
    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [KW-1:0]          strb;
        logic [KW-1:0]          keep;
        logic                   last;
        logic [ROUTE_WIDTH-1:0] id;
        logic [ROUTE_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0]  user;
    } beat_t;

    beat_t         mem [DEPTH];
    beat_t         in_beat;
    beat_t         m_beat_q, m_beat_d;
    logic          m_valid_q, m_valid_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW-1:0] occ;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d, beat_cnt_q, beat_cnt_d;
    logic          rst_flag_q;
    logic          push, pop, load, avail, rel_ok;

    // Occupancy counts the beat sitting in the output stage as well; that
    // beat stays at rd until it is popped.
    assign occ      = wr_q - rd_q;
    assign s_tready = !rst_flag_q && (occ != DEPTH_P);

    assign in_beat = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep, last: s_tlast,
                       id: s_tdest, dest: s_tid, user: s_tuser};

`ifdef UVMT_AXIS_ST_ECHO_STORE_FWD_EN
    logic [PW-1:0] cplt_q, cplt_d, cplt_left;
    logic          rel_q, rel_d;

    always_comb begin
        cplt_d    = cplt_q + PW'(push && s_tlast) - PW'(pop && m_beat_q.last);
        // complete packets still buffered once this edge's pop has happened
        cplt_left = cplt_q - PW'(pop && m_beat_q.last);
        rel_d     = rel_q;
        // Full with nothing complete: the head packet is oversize, stream it
        // out until its tlast leaves. The head cannot carry tlast here.
        if (occ == DEPTH_P && cplt_q == '0) rel_d = 1'b1;
        if (pop && m_beat_q.last)           rel_d = 1'b0;
        rel_ok    = (cplt_left != '0) || rel_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cplt_q <= '0;
            rel_q  <= 1'b0;
        end else begin
            cplt_q <= cplt_d;
            rel_q  <= rel_d;
        end
    end
`else
    assign rel_ok = 1'b1;
`endif

    always_comb begin
        push       = s_tvalid && s_tready;
        pop        = m_valid_q && m_tready;
        wr_d       = wr_q + PW'(push);
        rd_d       = rd_q + PW'(pop);
        // Only beats already in memory are eligible; a beat written on this
        // edge reaches the output stage on the next one.
        avail      = (wr_q - rd_d) != '0;
        load       = !m_valid_q || pop;
        m_valid_d  = m_valid_q;
        m_beat_d   = m_beat_q;
        if (load) begin
            m_valid_d = avail && rel_ok;
            if (avail && rel_ok) m_beat_d = mem[rd_d[AW-1:0]];
        end
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (pop) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
            pkt_cnt_d  = pkt_cnt_q + 16'(m_beat_q.last);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= in_beat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_flag_q <= 1'b1;
            wr_q       <= '0;
            rd_q       <= '0;
            m_valid_q  <= 1'b0;
            m_beat_q   <= '0;
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            rst_flag_q <= 1'b0;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            m_valid_q  <= m_valid_d;
            m_beat_q   <= m_beat_d;
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign m_tvalid = m_valid_q;
    assign m_tdata  = m_beat_q.data;
    assign m_tstrb  = m_beat_q.strb;
    assign m_tkeep  = m_beat_q.keep;
    assign m_tlast  = m_beat_q.last;
    assign m_tid    = m_beat_q.id;
    assign m_tdest  = m_beat_q.dest;
    assign m_tuser  = m_beat_q.user;
    assign pkt_cnt  = pkt_cnt_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_uvmt_axis_st_echo_dut.sv
// Directed bench for uvmt_axis_st_echo_dut: reset, single beat, fill and
// backpressure, streaming, reset mid-packet, random stalls, and the
// store-and-forward cases when UVMT_AXIS_ST_ECHO_STORE_FWD_EN is defined.
module tb_uvmt_axis_st_echo_dut;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_tvalid = 1'b0, s_tready;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0, s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tid = '0, s_tdest = '0, s_tuser = '0;
    logic        m_tvalid, m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb, m_tkeep;
    logic        m_tlast;
    logic [7:0]  m_tid, m_tdest, m_tuser;
    logic [15:0] pkt_cnt, beat_cnt;

    int checks = 0, errors = 0;
    int n_push = 0, n_pop = 0, exp_pkt = 0, exp_beat = 0, bubbles = 0;
    logic [64:0] sb[$];

    always #5 clk = ~clk;

    uvmt_axis_st_echo_dut dut (
        .clk(clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic last);
        s_tdata = $urandom();
        s_tstrb = 4'($urandom());
        s_tkeep = 4'($urandom());
        s_tlast = last;
        s_tid   = 8'($urandom());
        s_tdest = 8'($urandom());
        s_tuser = 8'($urandom());
    endtask

    // Scoreboard the handshakes about to complete, then advance one edge.
    task automatic cyc();
        if (s_tvalid && s_tready) begin
            sb.push_back({s_tdata, s_tstrb, s_tkeep, s_tlast, s_tdest, s_tid, s_tuser});
            n_push++;
        end
        if (m_tvalid && m_tready) begin
            chk("pop_with_empty_sb", 128'(sb.size() == 0), 128'd0);
            if (sb.size() != 0)
                chk("beat", {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser},
                    sb.pop_front());
            n_pop++;
            exp_beat++;
            if (m_tlast) exp_pkt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        sb.delete();
        exp_pkt  = 0;
        exp_beat = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_s_tready", s_tready, 0);
        reset = 1'b0;
        #1;
        chk("rst_after_s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        chk("rst_rise_s_tready", s_tready, 1);
    endtask

    // Push n beats and drain them. lastmod=0 means random tlast.
    task automatic stream(input string tag, input int n, input int lastmod,
                          input bit rnd, input int bound);
        int  k = 0;
        int  p;
        int  pop0 = n_pop;
        bit  started = 1'b0;
        bubbles  = 0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int c = 0; c < bound && (k < n || sb.size() != 0); c++) begin
            if (!s_tvalid && k < n && (!rnd || $urandom_range(1, 0) == 1)) begin
                set_beat(k == n - 1 || (lastmod != 0 && k % lastmod == lastmod - 1) ||
                         (lastmod == 0 && $urandom_range(7, 0) == 0));
                s_tvalid = 1'b1;
            end
            if (rnd) m_tready = 1'($urandom_range(1, 0));
            if (m_tvalid) started = 1'b1;
            else if (started) bubbles++;
            p = n_push;
            cyc();
            if (n_push != p) begin
                k++;
                s_tvalid = 1'b0;
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        chk({tag, "_pops"}, n_pop - pop0, n);
    endtask

    initial begin
        int k, p;
        #2;
        do_reset();

        // single beat
        m_tready = 1'b1;
        s_tdata = 32'hDEADBEEF; s_tstrb = 4'hF; s_tkeep = 4'hF; s_tlast = 1'b1;
        s_tid = 8'h12; s_tdest = 8'h34; s_tuser = 8'h5A;
        s_tvalid = 1'b1;
        cyc();
        s_tvalid = 1'b0;
        chk("single_latency_tvalid", m_tvalid, 0);
        cyc();
        chk("single_tvalid", m_tvalid, 1);
        chk("single_tdata", m_tdata, 32'hDEADBEEF);
        chk("single_tid", m_tid, 8'h34);
        chk("single_tdest", m_tdest, 8'h12);
        chk("single_tlast", m_tlast, 1);
        cyc();
        chk("single_pkt_cnt", pkt_cnt, 1);
        chk("single_beat_cnt", beat_cnt, 1);
        chk("single_drained", m_tvalid, 0);

        // fill and backpressure: 20 beats offered, 16 accepted while stalled
        m_tready = 1'b0;
        k = 0;
        set_beat(1'b0);
        s_tvalid = 1'b1;
        for (int c = 0; c < 25; c++) begin
            p = n_push;
            cyc();
            if (n_push != p) begin
                k++;
                if (k < 20) set_beat(k == 19);
                else s_tvalid = 1'b0;
            end
        end
        chk("fill_accepted", k, 16);
        chk("fill_s_tready", s_tready, 0);
        chk("fill_m_tvalid", m_tvalid, 1);
        chk("fill_head", {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}, sb[0]);
        m_tready = 1'b1;
        for (int c = 0; c < 100 && (k < 20 || sb.size() != 0); c++) begin
            p = n_push;
            cyc();
            if (n_push != p) begin
                k++;
                if (k < 20) set_beat(k == 19);
                else s_tvalid = 1'b0;
            end
        end
        chk("fill_total", k, 20);
        chk("fill_sb_empty", sb.size(), 0);
        chk("fill_pkt_cnt", pkt_cnt, 2);
        chk("fill_beat_cnt", beat_cnt, 21);

        // streaming: 10 packets of 10 beats back to back
        stream("stream", 100, 10, 1'b0, 400);
`ifndef UVMT_AXIS_ST_ECHO_STORE_FWD_EN
        chk("stream_bubbles", bubbles, 0);
`endif
        chk("stream_pkt_cnt", pkt_cnt, 12);
        chk("stream_beat_cnt", beat_cnt, 121);

        // reset mid-packet: 3 of 6 beats in flight, then a fresh packet
        m_tready = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            set_beat(1'b0);
            s_tvalid = 1'b1;
            p = n_push;
            cyc();
            if (n_push != p) k++;
        end
        chk("midpkt_pushed", k, 3);
        do_reset();
        stream("after_reset", 6, 6, 1'b0, 100);
        chk("after_reset_pkt_cnt", pkt_cnt, 1);
        chk("after_reset_beat_cnt", beat_cnt, 6);

        // random stalls on both sides
        do_reset();
        stream("random", 10000, 0, 1'b1, 60000);
        chk("random_beat_cnt", beat_cnt, 16'd10000);
        chk("random_pkt_cnt", pkt_cnt, 16'(exp_pkt));

`ifdef UVMT_AXIS_ST_ECHO_STORE_FWD_EN
        // store-and-forward: nothing leaves until tlast is buffered
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_beat(1'b0);
            s_tvalid = 1'b1;
            cyc();
            chk("sf_hold", m_tvalid, 0);
        end
        set_beat(1'b1);
        cyc();
        s_tvalid = 1'b0;
        chk("sf_tlast_edge", m_tvalid, 0);
        cyc();
        chk("sf_release", m_tvalid, 1);
        for (int c = 0; c < 20 && sb.size() != 0; c++) cyc();
        chk("sf_drained", sb.size(), 0);
        // oversize packet must escape through the full-FIFO release
        stream("sf_oversize", 20, 20, 1'b0, 300);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
